// File: rtl/fir_coeff_bank_ctrl.sv
// Double-buffered FIR coefficient bank: software edits a shadow bank, and a commit
// copies it to the active bank on a sample boundary, then tracks pipeline drain.
module fir_coeff_bank_ctrl #(
    parameter int unsigned NUM_TAPS      = 32,
    parameter int unsigned COEFF_W       = 16,
    parameter int unsigned DRAIN_SAMPLES = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0]   wr_addr,
    input  logic [COEFF_W-1:0]            wr_data,
    input  logic                          commit_req,
    input  logic                          fir_enable,
    input  logic                          sample_valid,
    output logic [NUM_TAPS*COEFF_W-1:0]   coeff_active,
    output logic                          commit_busy,
    output logic                          commit_done,
    output logic                          out_settled,
    output logic                          wr_err,
    output logic                          commit_err
);
    localparam int unsigned BANK_W = NUM_TAPS * COEFF_W;
    localparam int unsigned CNT_W  = $clog2(DRAIN_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, ARMED, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BANK_W-1:0] shadow_q, active_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              settled_q, settled_d;
    logic              wr_err_q, wr_err_d;
    logic              cmt_err_q, cmt_err_d;
    logic              copy;
    logic              shadow_we;

    // State register and all datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            settled_q <= 1'b1;
            wr_err_q  <= 1'b0;
            cmt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            settled_q <= settled_d;
            wr_err_q  <= wr_err_d;
            cmt_err_q <= cmt_err_d;
            if (shadow_we) begin
                shadow_q[wr_addr*COEFF_W +: COEFF_W] <= wr_data;
            end
            if (copy) begin
                active_q <= shadow_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (commit_req) state_d = ARMED;
            end
            ARMED: begin
                if (sample_valid || !fir_enable) state_d = fir_enable ? DRAIN : IDLE;
            end
            DRAIN: begin
                // Disabling the FIR clears its pipeline, so the drain is already complete.
                if (!fir_enable || (sample_valid && cnt_q == CNT_LAST)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        copy      = (state_q == ARMED) && (sample_valid || !fir_enable);
        shadow_we = (state_q == IDLE) && wr_en;
        cnt_d     = cnt_q;
        if (copy) begin
            cnt_d = '0;
        end else if (state_q == DRAIN && fir_enable && sample_valid) begin
            cnt_d = cnt_q + 1'b1;
        end
        done_d    = (state_q != IDLE) && (state_d == IDLE);
        settled_d = settled_q;
        if (copy && fir_enable) settled_d = 1'b0;
        if (done_d) settled_d = 1'b1;
        busy_d    = (state_d != IDLE);
        wr_err_d  = wr_en && (state_q != IDLE);
        cmt_err_d = commit_req && (state_q != IDLE);
    end

    assign coeff_active = active_q;
    assign commit_busy  = busy_q;
    assign commit_done  = done_q;
    assign out_settled  = settled_q;
    assign wr_err       = wr_err_q;
    assign commit_err   = cmt_err_q;
endmodule

// File: tb/tb_fir_coeff_bank_ctrl.sv
// Bench for fir_coeff_bank_ctrl: directed commit scenarios followed by random traffic,
// all checked cycle by cycle against a bank/countdown reference model.
module tb_fir_coeff_bank_ctrl;
    localparam int unsigned NT  = 32;
    localparam int unsigned CWD = 16;
    localparam int unsigned DS  = 6;
    localparam int unsigned BW  = NT * CWD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [4:0]    wr_addr = '0;
    logic [15:0]   wr_data = '0;
    logic          commit_req = 1'b0;
    logic          fir_enable = 1'b0;
    logic          sample_valid = 1'b0;
    logic [BW-1:0] coeff_active;
    logic          commit_busy, commit_done, out_settled, wr_err, commit_err;

    fir_coeff_bank_ctrl #(.NUM_TAPS(NT), .COEFF_W(CWD), .DRAIN_SAMPLES(DS)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit_req(commit_req), .fir_enable(fir_enable), .sample_valid(sample_valid),
        .coeff_active(coeff_active), .commit_busy(commit_busy), .commit_done(commit_done),
        .out_settled(out_settled), .wr_err(wr_err), .commit_err(commit_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int done_seen = 0;

    // Reference model: banks as arrays, commit progress as "pending copy" plus samples left.
    logic [15:0] m_sh [NT];
    logic [15:0] m_act [NT];
    bit m_busy, m_armed, m_done, m_settled, m_werr, m_cerr;
    int m_left;

    function automatic logic [BW-1:0] flat_act();
        logic [BW-1:0] f;
        for (int i = 0; i < NT; i++) f[i*CWD +: CWD] = m_act[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_busy = 0; m_armed = 0; m_done = 0; m_settled = 1; m_werr = 0; m_cerr = 0; m_left = 0;
    endtask

    task automatic model_edge(input bit we, input bit [4:0] a, input bit [15:0] d,
                              input bit cr, input bit en, input bit sv);
        m_done = 0; m_werr = 0; m_cerr = 0;
        if (!m_busy) begin
            if (we) m_sh[a] = d;
            if (cr) begin m_busy = 1; m_armed = 1; end
        end else begin
            m_werr = we;
            m_cerr = cr;
            if (m_armed) begin
                if (sv || !en) begin
                    m_act = m_sh;
                    m_armed = 0;
                    if (en) begin
                        m_settled = 0;
                        m_left = DS;
                    end else begin
                        m_busy = 0; m_done = 1; m_settled = 1;
                    end
                end
            end else if (!en) begin
                m_busy = 0; m_done = 1; m_settled = 1;
            end else if (sv) begin
                m_left--;
                if (m_left == 0) begin m_busy = 0; m_done = 1; m_settled = 1; end
            end
        end
    endtask

    task automatic check_w(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check_w("coeff_active", coeff_active, flat_act());
        check_b("commit_busy", commit_busy, m_busy);
        check_b("commit_done", commit_done, m_done);
        check_b("out_settled", out_settled, m_settled);
        check_b("wr_err", wr_err, m_werr);
        check_b("commit_err", commit_err, m_cerr);
    endtask

    task automatic step(input bit we, input bit [4:0] a, input bit [15:0] d,
                        input bit cr, input bit en, input bit sv);
        wr_en = we; wr_addr = a; wr_data = d;
        commit_req = cr; fir_enable = en; sample_valid = sv;
        model_edge(we, a, d, cr, en, sv);
        @(posedge clk);
        #1;
        if (commit_done) done_seen++;
        check_all();
    endtask

    initial begin
        bit en;
        // 1: reset state
        model_reset();
        #12;
        check_all();
        check_w("rst_active_zero", coeff_active, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2: commit while disabled
        step(1, 5'd0, 16'h4000, 0, 0, 0);
        step(1, 5'd31, 16'hC000, 0, 0, 0);
        step(0, 5'd0, 16'h0000, 1, 0, 0);
        step(0, 5'd0, 16'h0000, 0, 0, 0);
        step(0, 5'd0, 16'h0000, 0, 0, 0);
        check_w("t2_slice0", BW'(coeff_active[15:0]), BW'(16'h4000));
        check_w("t2_slice31", BW'(coeff_active[31*CWD +: CWD]), BW'(16'hC000));
        check_i("t2_done_once", done_seen, 1);

        // 3+4: commit while enabled, with rejected write/commit mid-drain
        step(1, 5'd5, 16'h1234, 0, 1, 0);
        step(0, 5'd0, 16'h0000, 1, 1, 0);
        for (int p = 0; p <= DS; p++) begin
            for (int k = 0; k < 3; k++) begin
                if (p == 3 && k == 0) step(1, 5'd5, 16'h7FFF, 1, 1, 0);
                else step(0, 5'd0, 16'h0000, 0, 1, 0);
                if (p == 0) check_w("t3_hold_before_copy", BW'(coeff_active[5*CWD +: CWD]), '0);
            end
            step(0, 5'd0, 16'h0000, 0, 1, 1);
        end
        step(0, 5'd0, 16'h0000, 0, 1, 0);
        check_i("t3_done_count", done_seen, 2);
        check_w("t3_slice5", BW'(coeff_active[5*CWD +: CWD]), BW'(16'h1234));
        step(0, 5'd0, 16'h0000, 1, 0, 0);
        step(0, 5'd0, 16'h0000, 0, 0, 0);
        step(0, 5'd0, 16'h0000, 0, 0, 0);
        check_w("t4_shadow_kept", BW'(coeff_active[5*CWD +: CWD]), BW'(16'h1234));

        // 5: disable during drain
        step(1, 5'd9, 16'h0055, 1, 1, 0);
        step(0, 5'd0, 16'h0000, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 5'd0, 16'h0000, 0, 1, 0);
            step(0, 5'd0, 16'h0000, 0, 1, 1);
        end
        step(0, 5'd0, 16'h0000, 0, 0, 0);
        check_b("t5_done", commit_done, 1'b1);
        check_b("t5_idle", commit_busy, 1'b0);
        check_b("t5_settled", out_settled, 1'b1);

        // 6: reset while ARMED, then write+commit in the same cycle
        step(0, 5'd0, 16'h0000, 1, 1, 0);
        step(0, 5'd0, 16'h0000, 0, 1, 0);
        begin
            int done_before;
            done_before = done_seen;
            #1 rst_n = 1'b0;
            #2;
            model_reset();
            check_all();
            check_i("t6_no_done", done_seen, done_before);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 5'd7, 16'h0100, 1, 1, 0);
        step(0, 5'd0, 16'h0000, 0, 1, 1);
        check_w("t6_slice7", BW'(coeff_active[7*CWD +: CWD]), BW'(16'h0100));
        for (int k = 0; k < DS; k++) begin
            step(0, 5'd0, 16'h0000, 0, 1, 0);
            step(0, 5'd0, 16'h0000, 0, 1, 1);
        end
        step(0, 5'd0, 16'h0000, 0, 1, 0);

        // Random traffic
        en = 1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(39) == 0) en = ~en;
            step(($urandom_range(3) == 0), 5'($urandom_range(NT - 1)), 16'($urandom),
                 ($urandom_range(11) == 0), en, ($urandom_range(2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
